// File: rtl/debug_reg_scanner_pkg.sv
// Shared definitions for the debug register scanner and the RV32core debug
// wiring at the top level.
//   DBG_ADDR_W / DBG_DATA_W : debug port address and data widths
//   SNAP_CNT_W              : width of the completed-sweep counter
//   scan_state_e            : scanner FSM states
package debug_scan_pkg;

  localparam int DBG_ADDR_W = 7;
  localparam int DBG_DATA_W = 32;
  localparam int SNAP_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    STEP_HI,
    STEP_LO,
    HOLD,
    CAPTURE,
    DONE
  } scan_state_e;

  // First state for every address: with no settle time the hold phase
  // disappears and the address is captured in the cycle it is presented.
  function automatic scan_state_e addr_entry_state(input int settle);
    return (settle == 0) ? CAPTURE : HOLD;
  endfunction

endpackage

// File: rtl/debug_reg_scanner_if.sv
// Bundle of the scanner's request, core debug port and host read signals.
//   master : host / core side (drives requests, debug_data, rd_addr)
//   slave  : scanner side (drives status, debug_addr/step, read data)
interface debug_reg_scanner_if;
  import debug_scan_pkg::*;

  logic                  scan_req;
  logic                  step_req;
  logic                  busy;
  logic                  done;
  logic [DBG_ADDR_W-1:0] debug_addr;
  logic [DBG_DATA_W-1:0] debug_data;
  logic                  debug_step;
  logic [DBG_ADDR_W-1:0] rd_addr;
  logic [DBG_DATA_W-1:0] rd_data;
  logic                  rd_changed;
  logic                  changed_any;
  logic [SNAP_CNT_W-1:0] snap_count;

  modport master (
    output scan_req, step_req, debug_data, rd_addr,
    input  busy, done, debug_addr, debug_step, rd_data, rd_changed,
           changed_any, snap_count
  );

  modport slave (
    input  scan_req, step_req, debug_data, rd_addr,
    output busy, done, debug_addr, debug_step, rd_data, rd_changed,
           changed_any, snap_count
  );

endinterface

// File: rtl/debug_reg_scanner_snap_ram.sv
// Snapshot buffer: NUM_ADDR words of debug data plus a changed flag each.
// Ports:
//   clk, rst (async, active-low: clears all entries and flags)
//   wr_en_i/wr_addr_i/wr_data_i : capture port; the flag is written with
//                                 (new data != stored data)
//   rd_addr_i -> rd_data_o/rd_changed_o : registered host read, 0/0 when
//                                 the address is outside the buffer
//   changed_any_o : OR of all flags (combinational)
module debug_snap_ram
  import debug_scan_pkg::*;
#(
  parameter int NUM_ADDR = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DBG_ADDR_W-1:0] wr_addr_i,
  input  logic [DBG_DATA_W-1:0] wr_data_i,
  input  logic [DBG_ADDR_W-1:0] rd_addr_i,
  output logic [DBG_DATA_W-1:0] rd_data_o,
  output logic                  rd_changed_o,
  output logic                  changed_any_o
);

  // Storage is rounded up to a power of two so entries can be selected by
  // a plain slice of the address; the range checks keep the spare entries
  // unwritten and unreadable.
  localparam int IDX_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [DBG_ADDR_W:0] NUM_ADDR_L = (DBG_ADDR_W+1)'(NUM_ADDR);

  logic [DBG_DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      flag_q;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_idx = wr_addr_i[IDX_W-1:0];
  assign rd_idx = rd_addr_i[IDX_W-1:0];
  assign wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < NUM_ADDR_L);
  assign rd_ok  = {1'b0, rd_addr_i} < NUM_ADDR_L;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      flag_q <= '0;
    end else if (wr_ok) begin
      data_q[wr_idx] <= wr_data_i;
      flag_q[wr_idx] <= (wr_data_i != data_q[wr_idx]);
    end
  end

  // Reads sample the array before this edge's write lands, so a read and a
  // capture of the same entry in one cycle return the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_o    <= '0;
      rd_changed_o <= 1'b0;
    end else if (rd_ok) begin
      rd_data_o    <= data_q[rd_idx];
      rd_changed_o <= flag_q[rd_idx];
    end else begin
      rd_data_o    <= '0;
      rd_changed_o <= 1'b0;
    end
  end

  assign changed_any_o = |flag_q;

endmodule

// File: rtl/debug_reg_scanner.sv
// Sweeps the core debug port over addresses 0..NUM_ADDR-1, optionally after
// a single step pulse, and stores each sweep in a snapshot buffer with
// per-entry changed flags for a host to read.
// Ports:
//   clk  : core clock
//   rst  : async reset, active-low
//   bus  : debug_reg_scanner_if.slave (requests, status, debug port,
//          host read port, changed_any, snap_count)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for scan_req / step_req, debug_addr = 0
// STEP_HI | debug_step high for STEP_WIDTH cycles
// STEP_LO | debug_step low for STEP_WIDTH cycles before the sweep
// HOLD    | debug_addr presented for SETTLE cycles
// CAPTURE | debug_data written into the buffer entry at debug_addr
// DONE    | done pulse, snap_count and changed_any updated
module debug_reg_scanner
  import debug_scan_pkg::*;
#(
  parameter int NUM_ADDR   = 32,
  parameter int SETTLE     = 1,
  parameter int STEP_WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  debug_reg_scanner_if.slave bus
);

  localparam logic [DBG_ADDR_W-1:0] LAST_ADDR = DBG_ADDR_W'(NUM_ADDR - 1);
  // Down-counters load width-1 so the terminal count 0 marks the last cycle.
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [7:0]  STEP_LD   = 8'(STEP_WIDTH - 1);
  localparam scan_state_e ENTRY_ST  = addr_entry_state(SETTLE);

  scan_state_e           state_q, state_d;
  logic [DBG_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [SNAP_CNT_W-1:0] snap_count_q;
  logic                  changed_any_q;
  logic                  wr_en;
  logic                  flags_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        // A step request wins over a simultaneous scan request; the sweep
        // that follows the step covers both.
        if (bus.step_req) begin
          state_d = STEP_HI;
          cnt_d   = STEP_LD;
        end else if (bus.scan_req) begin
          state_d = ENTRY_ST;
          addr_d  = '0;
          cnt_d   = SETTLE_LD;
        end
      end
      STEP_HI: begin
        if (cnt_q == '0) begin
          state_d = STEP_LO;
          cnt_d   = STEP_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STEP_LO: begin
        if (cnt_q == '0) begin
          state_d = ENTRY_ST;
          addr_d  = '0;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
          addr_d  = '0;
        end else begin
          state_d = ENTRY_ST;
          addr_d  = addr_q + 1'b1;
          cnt_d   = SETTLE_LD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_count_q  <= '0;
      changed_any_q <= 1'b0;
    end else if (state_q == DONE) begin
      snap_count_q  <= snap_count_q + 1'b1;
      changed_any_q <= flags_any;
    end
  end

  debug_snap_ram #(
    .NUM_ADDR (NUM_ADDR)
  ) u_snap_ram (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en),
    .wr_addr_i     (addr_q),
    .wr_data_i     (bus.debug_data),
    .rd_addr_i     (bus.rd_addr),
    .rd_data_o     (bus.rd_data),
    .rd_changed_o  (bus.rd_changed),
    .changed_any_o (flags_any)
  );

  assign bus.busy        = (state_q == STEP_HI) || (state_q == STEP_LO) ||
                           (state_q == HOLD)    || (state_q == CAPTURE);
  assign bus.done        = (state_q == DONE);
  assign bus.debug_step  = (state_q == STEP_HI);
  assign bus.debug_addr  = addr_q;
  assign bus.changed_any = changed_any_q;
  assign bus.snap_count  = snap_count_q;

endmodule
